fofir_tap_sequencer: RTL and testbench
======================================

Name: fofir_tap_sequencer

Overview:
- Upstream feeder of the FoFIR tap multiplexer inside the PE.
- Holds a 5-deep sample delay line (tap0 newest … tap4 oldest) and presents all five taps in parallel.
- Once the window is full, each newly accepted sample triggers a scan: sel steps 0→4, one value per accepted beat, so the downstream 5-input mux serialises the window to the MAC.

Parameters:
- data_width, 16, bit width of each sample and tap.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of window and scan; highest priority.
- in_data  input  data_width  incoming sample.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  sequencer accepts a sample this cycle.
- tap0..tap4  output  data_width each  delay-line contents; drive mux in0..in4.
- sel  output  3  tap select to mux, 0..4 only.
- sel_valid  output  1  sel/taps form a valid selection this cycle.
- sel_ready  input  1  downstream consumes current selection.
- sel_last  output  1  high with sel_valid when sel==4.
- window_full  output  1  five samples have been loaded since reset/flush.

Behaviour:
- Reset (rst_n low, async): tap0..tap4=0, sel=0, fill_cnt=0, state=IDLE.
  - Reset outputs: sel_valid=0, sel_last=0, window_full=0, in_ready=1.
- Reset mid-scan aborts immediately. No partial scan resumes.
- States: IDLE, SCAN (1-bit encoding).
- in_ready = (state==IDLE) && !flush. This is combinational.
- Load, on in_valid && in_ready:
  - tap4<=tap3, tap3<=tap2, tap2<=tap1, tap1<=tap0, tap0<=in_data.
  - fill_cnt increments and saturates at 5.
- IDLE→SCAN on a load where post-load fill_cnt==5; sel<=0.
  - Loads with post-load fill_cnt<5 (warm-up) stay in IDLE and produce no scan.
- SCAN behaviour:
  - sel_valid=1, taps frozen, in_ready=0.
  - On sel_ready with sel<4: sel<=sel+1.
  - On sel_ready with sel==4: sel<=0, state<=IDLE.
  - Without sel_ready: sel and taps hold. Back-pressure is unlimited.
- sel_last = sel_valid && sel==4.
- window_full = (fill_cnt==5).
- Latency:
  - Sample accepted at edge N (completing the window) → sel_valid=1 with sel=0 in cycle N+1.
  - With sel_ready tied high, five scan cycles follow; in_ready returns in cycle N+6.
  - Peak rate is 1 sample / 6 cycles.
- flush (synchronous, any state):
  - Next edge: taps=0, fill_cnt=0, sel=0, state=IDLE.
  - in_valid in the same cycle is not accepted, because in_ready is 0.
  - sel_ready in the same cycle is ignored.
- sel never takes 5..7. Verification asserts this.
- No arithmetic beyond the 3-bit sel counter and the 3-bit saturating fill_cnt.

Decomposition:
- Shared package fofir_pkg holds:
  - NUM_TAPS=5, SEL_W=3.
  - State encoding constants ST_IDLE=1'b0, ST_SCAN=1'b1.
- Sub-module fofir_tap_shift_reg holds:
  - The 5×data_width delay line with shift-enable and sync clear.
  - Parallel outputs tap0..tap4.
- The FSM, sel counter and fill_cnt stay in fofir_tap_sequencer.

Test Plan:
- Reset then warm-up: load 0x0001..0x0004 with in_valid every cycle → window_full=0, sel_valid never 1, tap0=0x0004, tap3=0x0001.
- Fifth load 0x0005, sel_ready=1 → next cycle sel_valid=1, and sel/tap value sequence is 0/0x0005, 1/0x0004, 2/0x0003, 3/0x0002, 4/0x0001 on consecutive cycles. sel_last only on the sel=4 beat; in_ready=1 the cycle after.
- Back-pressure: sel_ready low for 3 cycles at sel=2 → sel stays 2, taps unchanged, in_ready=0, in_valid ignored. Scan then completes 3,4.
- Steady state: sample 0x0006 loaded → tap0=0x0006, tap4=0x0002, and a new 5-beat scan starts at sel=0.
- Flush at sel=3 → next cycle sel_valid=0, window_full=0, all taps=0, in_ready=1. A following load does not start a scan.
- Async reset asserted mid-scan, between clock edges → outputs drop to reset values immediately; after release the block behaves as in the warm-up test.

Source files
------------

// File: rtl/fofir_pkg.sv
// Shared constants and state type for the FoFIR tap sequencer slice.
package fofir_pkg;

  localparam int NUM_TAPS = 5;
  localparam int SEL_W    = 3;
  localparam int FILL_W   = 3;

  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_TAPS - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(NUM_TAPS);
  localparam logic [FILL_W-1:0] FILL_PRE  = FILL_W'(NUM_TAPS - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/fofir_tap_shift_reg.sv
// Five-deep sample delay line with shift enable and synchronous clear.
// Tap 0 holds the newest sample and tap 4 the oldest.
module fofir_tap_shift_reg
  import fofir_pkg::*;
#(
  parameter int data_width = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_shift_en,
  input  logic                  i_clear,
  input  logic [data_width-1:0] i_data,
  output logic [data_width-1:0] o_tap0,
  output logic [data_width-1:0] o_tap1,
  output logic [data_width-1:0] o_tap2,
  output logic [data_width-1:0] o_tap3,
  output logic [data_width-1:0] o_tap4
);

  logic [data_width-1:0] r_taps [NUM_TAPS];

  // NOTE: this storage is reset because every entry is a visible output;
  // a reset-free array would leave X on the taps until the window fills.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TAPS; i++) r_taps[i] <= '0;
    end else if (i_clear) begin
      for (int i = 0; i < NUM_TAPS; i++) r_taps[i] <= '0;
    end else if (i_shift_en) begin
      r_taps[0] <= i_data;
      for (int i = 1; i < NUM_TAPS; i++) r_taps[i] <= r_taps[i-1];
    end
  end

  assign o_tap0 = r_taps[0];
  assign o_tap1 = r_taps[1];
  assign o_tap2 = r_taps[2];
  assign o_tap3 = r_taps[3];
  assign o_tap4 = r_taps[4];

endmodule

// File: rtl/fofir_tap_sequencer.sv
// Feeds the FoFIR tap mux: keeps a 5-sample window and, once it is full,
// walks sel 0..4 over the frozen window after every newly accepted sample.
module fofir_tap_sequencer
  import fofir_pkg::*;
#(
  parameter int data_width = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [data_width-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [data_width-1:0] tap0,
  output logic [data_width-1:0] tap1,
  output logic [data_width-1:0] tap2,
  output logic [data_width-1:0] tap3,
  output logic [data_width-1:0] tap4,
  output logic [SEL_W-1:0]      sel,
  output logic                  sel_valid,
  input  logic                  sel_ready,
  output logic                  sel_last,
  output logic                  window_full
);

  state_e              r_state;
  logic [SEL_W-1:0]    r_sel;
  logic [FILL_W-1:0]   r_fill_cnt;

  state_e              w_state_nxt;
  logic [SEL_W-1:0]    w_sel_nxt;
  logic [FILL_W-1:0]   w_fill_nxt;
  logic                w_load;

  assign in_ready = (r_state == ST_IDLE) && !flush;
  assign w_load   = in_valid && in_ready;

  fofir_tap_shift_reg #(
    .data_width (data_width)
  ) u_shift_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_shift_en (w_load),
    .i_clear    (flush),
    .i_data     (in_data),
    .o_tap0     (tap0),
    .o_tap1     (tap1),
    .o_tap2     (tap2),
    .o_tap3     (tap3),
    .o_tap4     (tap4)
  );

  // NOTE: every signal is defaulted to its held value first so no path
  // through the case below can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_fill_nxt  = r_fill_cnt;
    if (flush) begin
      w_state_nxt = ST_IDLE;
      w_sel_nxt   = '0;
      w_fill_nxt  = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            if (r_fill_cnt != FILL_FULL) w_fill_nxt = r_fill_cnt + FILL_W'(1);
            // A load that leaves the window full starts a fresh scan.
            if (r_fill_cnt == FILL_PRE || r_fill_cnt == FILL_FULL) begin
              w_state_nxt = ST_SCAN;
              w_sel_nxt   = '0;
            end
          end
        end
        ST_SCAN: begin
          if (sel_ready) begin
            if (r_sel == SEL_LAST) begin
              w_sel_nxt   = '0;
              w_state_nxt = ST_IDLE;
            end else begin
              w_sel_nxt = r_sel + SEL_W'(1);
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // NOTE: non-blocking assignments keep all state updates on this edge
  // independent of the order in which the statements are written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_sel      <= '0;
      r_fill_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_sel      <= w_sel_nxt;
      r_fill_cnt <= w_fill_nxt;
    end
  end

  assign sel         = r_sel;
  assign sel_valid   = (r_state == ST_SCAN);
  assign sel_last    = sel_valid && (r_sel == SEL_LAST);
  assign window_full = (r_fill_cnt == FILL_FULL);

endmodule

// File: tb/tb_fofir_tap_sequencer.sv
// Self-checking bench: fixed warm-up/scan table, hand-written corner
// sequences and randomized traffic against a window/beat-count model.
module tb_fofir_tap_sequencer;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] tap0, tap1, tap2, tap3, tap4;
  logic [2:0]    sel;
  logic          sel_valid;
  logic          sel_ready;
  logic          sel_last;
  logic          window_full;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fofir_tap_sequencer #(.data_width(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .tap0        (tap0),
    .tap1        (tap1),
    .tap2        (tap2),
    .tap3        (tap3),
    .tap4        (tap4),
    .sel         (sel),
    .sel_valid   (sel_valid),
    .sel_ready   (sel_ready),
    .sel_last    (sel_last),
    .window_full (window_full)
  );

  // Reference model: the window as a list (index 0 newest), the number of
  // samples seen since clear, and the number of scan beats still owed.
  logic [DW-1:0] m_win [5];
  int            m_fill;
  int            m_left;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          sr;
    logic          fl;
    logic          e_ready;
    logic          e_sv;
    logic          e_last;
    logic          e_full;
    logic [2:0]    e_sel;
    logic [DW-1:0] e_tap0;
    logic [DW-1:0] e_tap3;
    logic [DW-1:0] e_mux;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mux_out();
    case (sel)
      3'd0:    return tap0;
      3'd1:    return tap1;
      3'd2:    return tap2;
      3'd3:    return tap3;
      3'd4:    return tap4;
      default: return 'x;
    endcase
  endfunction

  function automatic vec_t mk(logic v, logic [DW-1:0] d, logic sr, logic fl,
                              logic rdy, logic sv, logic last, logic full, logic [2:0] s,
                              logic [DW-1:0] t0, logic [DW-1:0] t3, logic [DW-1:0] mx);
    vec_t r;
    r.v = v; r.d = d; r.sr = sr; r.fl = fl;
    r.e_ready = rdy; r.e_sv = sv; r.e_last = last; r.e_full = full; r.e_sel = s;
    r.e_tap0 = t0; r.e_tap3 = t3; r.e_mux = mx;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_win[i] = '0;
    m_fill = 0;
    m_left = 0;
  endtask

  task automatic model_advance();
    if (flush) begin
      model_reset();
    end else if (m_left > 0) begin
      if (sel_ready) m_left--;
    end else if (in_valid) begin
      for (int i = 4; i > 0; i--) m_win[i] = m_win[i-1];
      m_win[0] = in_data;
      if (m_fill < 5) m_fill++;
      if (m_fill == 5) m_left = 5;
    end
  endtask

  task automatic model_check();
    logic       e_ready, e_sv, e_last, e_full;
    logic [2:0] e_sel;
    e_sv    = (m_left > 0);
    e_ready = !e_sv && !flush;
    e_sel   = e_sv ? 3'(5 - m_left) : 3'd0;
    e_last  = (m_left == 1);
    e_full  = (m_fill == 5);
    check("model_ctrl", {in_ready, sel_valid, sel_last, window_full, sel},
                        {e_ready, e_sv, e_last, e_full, e_sel});
    check("model_taps", {tap0, tap1, tap2, tap3, tap4},
                        {m_win[0], m_win[1], m_win[2], m_win[3], m_win[4]});
    check("sel_range", {127'd0, (sel <= 3'd4)}, 128'd1);
  endtask

  // Inputs change on the falling edge; outputs are compared 1 ns later.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic sr, input logic fl);
    in_valid  = v;
    in_data   = d;
    sel_ready = sr;
    flush     = fl;
    #1;
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  task automatic run_table();
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].sr, tbl[i].fl);
      check($sformatf("tbl_ctrl[%0d]", i),
            {in_ready, sel_valid, sel_last, window_full, sel},
            {tbl[i].e_ready, tbl[i].e_sv, tbl[i].e_last, tbl[i].e_full, tbl[i].e_sel});
      check($sformatf("tbl_taps[%0d]", i), {tap0, tap3, mux_out()},
            {tbl[i].e_tap0, tbl[i].e_tap3, tbl[i].e_mux});
      tick();
    end
  endtask

  initial begin
    //                v  d   sr fl  rdy sv last full sel  tap0 tap3 mux
    tbl[0]  = mk(1, 16'h1, 0, 0,  1, 0, 0, 0, 3'd0, 16'h0, 16'h0, 16'h0);
    tbl[1]  = mk(1, 16'h2, 0, 0,  1, 0, 0, 0, 3'd0, 16'h1, 16'h0, 16'h1);
    tbl[2]  = mk(1, 16'h3, 0, 0,  1, 0, 0, 0, 3'd0, 16'h2, 16'h0, 16'h2);
    tbl[3]  = mk(1, 16'h4, 0, 0,  1, 0, 0, 0, 3'd0, 16'h3, 16'h0, 16'h3);
    tbl[4]  = mk(1, 16'h5, 0, 0,  1, 0, 0, 0, 3'd0, 16'h4, 16'h1, 16'h4);
    tbl[5]  = mk(0, 16'h0, 1, 0,  0, 1, 0, 1, 3'd0, 16'h5, 16'h2, 16'h5);
    tbl[6]  = mk(0, 16'h0, 1, 0,  0, 1, 0, 1, 3'd1, 16'h5, 16'h2, 16'h4);
    tbl[7]  = mk(0, 16'h0, 1, 0,  0, 1, 0, 1, 3'd2, 16'h5, 16'h2, 16'h3);
    tbl[8]  = mk(0, 16'h0, 1, 0,  0, 1, 0, 1, 3'd3, 16'h5, 16'h2, 16'h2);
    tbl[9]  = mk(0, 16'h0, 1, 0,  0, 1, 1, 1, 3'd4, 16'h5, 16'h2, 16'h1);
    tbl[10] = mk(0, 16'h0, 0, 0,  1, 0, 0, 1, 3'd0, 16'h5, 16'h2, 16'h5);

    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; sel_ready = 1'b0; flush = 1'b0;
    model_reset();
    @(negedge clk);
    check("reset_state", {in_ready, sel_valid, sel_last, window_full, sel, tap0, tap4},
                         {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0});
    @(negedge clk);
    rst_n = 1'b1;

    // Warm-up and the first full scan.
    run_table();

    // Steady state: one more sample starts a new scan over the shifted window.
    drive(1, 16'h6, 0, 0); tick();
    drive(0, 16'h0, 1, 0);
    check("steady_start", {sel_valid, sel, tap0, tap4}, {1'b1, 3'd0, 16'h6, 16'h2});
    tick();
    drive(0, 16'h0, 1, 0); tick();

    // Back-pressure at sel=2 with a sample offered that must be ignored.
    for (int i = 0; i < 3; i++) begin
      drive(1, 16'hBEEF, 0, 0);
      check("bp_hold", {sel_valid, sel, in_ready, tap0, tap4}, {1'b1, 3'd2, 1'b0, 16'h6, 16'h2});
      tick();
    end
    drive(0, 16'h0, 1, 0); check("bp_resume2", {sel, mux_out()}, {3'd2, 16'h4}); tick();
    drive(0, 16'h0, 1, 0); check("bp_resume3", {sel, mux_out()}, {3'd3, 16'h3}); tick();
    drive(0, 16'h0, 1, 0); check("bp_last", {sel, sel_last, mux_out()}, {3'd4, 1'b1, 16'h2}); tick();
    drive(0, 16'h0, 0, 0);
    check("bp_done", {in_ready, sel_valid, tap0}, {1'b1, 1'b0, 16'h6});
    tick();

    // Flush at sel=3, with a sample and sel_ready offered in the same cycle.
    drive(1, 16'h7, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin drive(0, 16'h0, 1, 0); tick(); end
    drive(1, 16'h1234, 1, 1);
    check("flush_cycle", {in_ready, sel}, {1'b0, 3'd3});
    tick();
    drive(0, 16'h0, 0, 0);
    check("flush_after", {sel_valid, window_full, in_ready, tap0, tap1, tap2, tap3, tap4},
                         {1'b0, 1'b0, 1'b1, 80'h0});
    tick();
    drive(1, 16'h9, 0, 0); tick();
    drive(0, 16'h0, 0, 0);
    check("flush_reload", {sel_valid, window_full, tap0, tap1}, {1'b0, 1'b0, 16'h9, 16'h0});
    tick();

    // Async reset between edges during a scan.
    for (int i = 0; i < 4; i++) begin drive(1, 16'(16'hA0 + i), 0, 0); tick(); end
    drive(0, 16'h0, 1, 0); tick();
    drive(0, 16'h0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {in_ready, sel_valid, sel_last, window_full, sel, tap0, tap1, tap2, tap3, tap4},
                         {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 80'h0});
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run_table();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 9) < 7), DW'($urandom), ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 49) == 0));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
